// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word
// per line. A CPU read hit completes in the same cycle; misses fill the line
// from backing memory and the held request is then retried as a hit. Stores
// always go to memory and update the line only when it already holds the
// address.
//
// Optional build macro: DCACHE_STATS_EN adds 32-bit hit_count/miss_count
// outputs counting completed CPU accesses.
module dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  cache_waitrequest,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        FILL_REQ,
        FILL_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t                  state;
    logic [LINES-1:0]        valid_q;
    logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES];

    // Captured request: memory side works from these so it never depends on
    // the CPU bus after the transaction has started.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    mem_rd_q;
    logic                    mem_wr_q;

    logic [INDEX_BITS-1:0]   cpu_index;
    logic [TAG_WIDTH-1:0]    cpu_tag;
    logic [INDEX_BITS-1:0]   q_index;
    logic [TAG_WIDTH-1:0]    q_tag;
    logic                    cpu_hit;
    logic                    q_hit;
    logic                    fill_we;
    logic                    wr_hit_we;

    assign cpu_index = cache_addr[INDEX_BITS-1:0];
    assign cpu_tag   = cache_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign q_index   = addr_q[INDEX_BITS-1:0];
    assign q_tag     = addr_q[ADDR_WIDTH-1:INDEX_BITS];

    // Lookup against the live CPU address (IDLE decisions) and the captured
    // address (write-hit update at memory acceptance).
    assign cpu_hit = (cache_rd || cache_wr) && valid_q[cpu_index]
                     && (tag_mem[cpu_index] == cpu_tag);
    assign q_hit   = valid_q[q_index] && (tag_mem[q_index] == q_tag);

    assign fill_we   = (state == FILL_WAIT) && mem_rd_valid;
    assign wr_hit_we = (state == WRITE) && !mem_waitrequest && q_hit;

    assign cache_data  = data_mem[cpu_index];
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;

    // CPU stall: only IDLE depends on the request; RESP releases the store.
    always_comb begin
        // NOTE: default assignment first so every path drives the output and
        // no latch is inferred.
        cache_waitrequest = 1'b1;
        case (state)
            IDLE:    cache_waitrequest = cache_wr || (cache_rd && !cpu_hit);
            RESP:    cache_waitrequest = 1'b0;
            default: cache_waitrequest = 1'b1;
        endcase
    end

    // Controller FSM with registered memory strobes and valid bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            valid_q  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (cache_wr) begin
                        // A simultaneous read is dropped: the store wins.
                        addr_q   <= cache_addr;
                        wdata_q  <= cache_wr_data;
                        mem_wr_q <= 1'b1;
                        state    <= WRITE;
                    end else if (cache_rd && !cpu_hit) begin
                        addr_q   <= cache_addr;
                        mem_rd_q <= 1'b1;
                        state    <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_rd_q <= 1'b0;
                        state    <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rd_valid) begin
                        valid_q[q_index] <= 1'b1;
                        state            <= IDLE;
                    end
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        mem_wr_q <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage: filled on read return, patched on a write hit.
    // NOTE: no reset on the arrays; the valid bits alone decide whether a
    // line's contents mean anything.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            tag_mem[q_index]  <= q_tag;
            data_mem[q_index] <= mem_rd_data;
        end else if (wr_hit_we) begin
            data_mem[q_index] <= wdata_q;
        end
    end

`ifdef DCACHE_STATS_EN
    logic fill_done_q;
    logic wr_hit_q;

    // Access counters: a read that needed a fill counts as a miss when its
    // retry completes; stores count when RESP releases the CPU.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            fill_done_q <= 1'b0;
            wr_hit_q    <= 1'b0;
        end else begin
            if (fill_we) begin
                fill_done_q <= 1'b1;
            end else if (state == IDLE) begin
                fill_done_q <= 1'b0;
                if (cache_rd && !cache_wr && cpu_hit) begin
                    if (fill_done_q) miss_count <= miss_count + 32'd1;
                    else             hit_count  <= hit_count + 32'd1;
                end
            end
            if ((state == WRITE) && !mem_waitrequest) begin
                wr_hit_q <= q_hit;
            end
            if (state == RESP) begin
                if (wr_hit_q) hit_count  <= hit_count + 32'd1;
                else          miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
